// File: rtl/hello_psalm_sequencer.sv
// Psalm RAM read sequencer: walks the RAM from address 0 and strobes each byte to the UART.
// Optional PSALM_LOOP_EN: PAUSE restarts the message at address 0 instead of returning to IDLE.
module hello_psalm_sequencer #(
   parameter int unsigned   AW           = 11,
   parameter int unsigned   DW           = 8,
   parameter int unsigned   MSGLEN       = 1600,
   parameter logic [DW-1:0] TERM_CHAR    = 8'h00,
   parameter int unsigned   PAUSE_CYCLES = 1000
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   output logic [AW-1:0] o_mem_addr,
   input  logic [DW-1:0] i_mem_data,
   output logic          o_stb,
   output logic [DW-1:0] o_data,
   input  logic          i_busy,
   output logic          o_busy,
   output logic          o_done
);

   localparam int unsigned CW         = 32;
   localparam logic [AW-1:0] LAST_ADDR  = AW'(MSGLEN - 1);
   localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SEND  = 3'd3,
      PAUSE = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic          stb_q,   stb_d;
   logic [DW-1:0] data_q,  data_d;
   logic          done_q,  done_d;
   logic          busy_q,  busy_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // State register; synchronous reset drops any strobe in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         stb_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         stb_q   <= stb_d;
         data_q  <= data_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      stb_d   = stb_q;
      data_d  = data_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               addr_d  = '0;
               state_d = FETCH;
            end
         end

         FETCH: begin
            state_d = LOAD;
         end

         LOAD: begin
            // Terminator ends the message without ever reaching the transmitter.
            if (i_mem_data == TERM_CHAR) begin
               done_d  = 1'b1;
               cnt_d   = PAUSE_LOAD;
               state_d = PAUSE;
            end else begin
               data_d  = i_mem_data;
               stb_d   = 1'b1;
               state_d = SEND;
            end
         end

         SEND: begin
            if (stb_q && !i_busy) begin
               stb_d = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  cnt_d   = PAUSE_LOAD;
                  state_d = PAUSE;
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = FETCH;
               end
            end
         end

         PAUSE: begin
            if (cnt_q == '0) begin
`ifdef PSALM_LOOP_EN
               addr_d  = '0;
               state_d = FETCH;
`else
               state_d = IDLE;
`endif
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign o_mem_addr = addr_q;
   assign o_stb      = stb_q;
   assign o_data     = data_q;
   assign o_done     = done_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_hello_psalm_sequencer.sv
// Bench for hello_psalm_sequencer: directed timing cases plus randomized messages
// scored against the byte list derived from the RAM image.
module tb_hello_psalm_sequencer;

   localparam int unsigned AW           = 3;
   localparam int unsigned DW           = 8;
   localparam int unsigned MSGLEN       = 8;
   localparam int unsigned PAUSE_CYCLES = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy_in;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          stb;
   logic [DW-1:0] data;
   logic          busy_out;
   logic          done;

   logic [DW-1:0] ram [MSGLEN];
   logic [DW-1:0] exp_q [$];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   // Registered-read RAM model.
   always @(posedge clk) mem_data <= ram[mem_addr];

   hello_psalm_sequencer #(
      .AW          (AW),
      .DW          (DW),
      .MSGLEN      (MSGLEN),
      .TERM_CHAR   (8'h00),
      .PAUSE_CYCLES(PAUSE_CYCLES)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_start   (start),
      .o_mem_addr(mem_addr),
      .i_mem_data(mem_data),
      .o_stb     (stb),
      .o_data    (data),
      .i_busy    (busy_in),
      .o_busy    (busy_out),
      .o_done    (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  rel;
      bit  active;
      bit  exp_stb;
      int  exp_addr;
      int  cyc;
      int  abort_at;
      int  n_xfer;
      bit  saw_done;
      bit  prev_hold;
      logic [DW-1:0] prev_data;

      rst     = 1'b1;
      start   = 1'b0;
      busy_in = 1'b0;
      for (int i = 0; i < int'(MSGLEN); i++) ram[i] = 8'(8'h41 + i);

      // Reset state
      step();
      step();
      check_eq("rst_stb",  32'(stb),      32'd0);
      check_eq("rst_done", 32'(done),     32'd0);
      check_eq("rst_busy", 32'(busy_out), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_data", 32'(data),     32'd0);

      // Full message, busy tied low; byte k strobed at cycle 3+3k, done after the last.
      rst   = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         step();
         rel    = c;
         active = 1'b1;
         if (c >= 30) begin
`ifdef PSALM_LOOP_EN
            rel = c - 29;
`else
            active = 1'b0;
`endif
         end
         exp_stb = active && rel >= 3 && ((rel - 3) % 3 == 0) && ((rel - 3) / 3 < int'(MSGLEN));
         check_eq("full_stb",  32'(stb),      32'(exp_stb));
         check_eq("full_done", 32'(done),     32'(c == 25));
         check_eq("full_busy", 32'(busy_out), 32'(active));
         if (exp_stb) check_eq("full_data", 32'(data), 32'(ram[(rel - 3) / 3]));
         if (c <= 29) begin
            exp_addr = (c - 1) / 3;
            if (exp_addr > int'(MSGLEN) - 1) exp_addr = int'(MSGLEN) - 1;
            check_eq("full_addr", 32'(mem_addr), 32'(exp_addr));
         end
         start = (c == 25 || c == 27);
      end
      start = 1'b0;

      // Backpressure hold, then reset in the middle of a strobe.
      rst = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (c >= 3 && c <= 13) begin
            check_eq("hold_stb",  32'(stb),  32'd1);
            check_eq("hold_data", 32'(data), 32'h41);
         end
         if (c == 14 || c == 15) check_eq("hold_gap", 32'(stb), 32'd0);
         if (c == 14) check_eq("hold_addr", 32'(mem_addr), 32'd1);
         if (c == 16) begin
            check_eq("hold_next_stb",  32'(stb),  32'd1);
            check_eq("hold_next_data", 32'(data), 32'h42);
            rst     = 1'b1;
            busy_in = 1'b1;
         end
         if (c == 17) begin
            check_eq("mid_rst_stb",  32'(stb),      32'd0);
            check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
            check_eq("mid_rst_busy", 32'(busy_out), 32'd0);
            check_eq("mid_rst_done", 32'(done),     32'd0);
            rst     = 1'b0;
            busy_in = 1'b0;
         end
         if (c == 3)  busy_in = 1'b1;
         if (c == 13) busy_in = 1'b0;
      end
      start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         start = 1'b0;
         check_eq("replay_stb", 32'(stb), 32'(c == 3));
         if (c == 3) check_eq("replay_data", 32'(data), 32'h41);
      end

      // Terminator at address 1: only the first byte goes out.
      ram[0] = 8'h48;
      ram[1] = 8'h00;
      ram[2] = 8'h49;
      rst = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         start = 1'b0;
         check_eq("term1_stb",  32'(stb),  32'(c == 3));
         check_eq("term1_done", 32'(done), 32'(c == 6));
         if (c == 3) check_eq("term1_data", 32'(data), 32'h48);
         if (c >= 4 && c <= 10) check_eq("term1_addr", 32'(mem_addr), 32'd1);
         if (c <= 10) check_eq("term1_busy", 32'(busy_out), 32'd1);
      end

      // Terminator at address 0: nothing sent, done two cycles after FETCH.
      ram[0] = 8'h00;
      rst = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         start = 1'b0;
         check_eq("term0_stb",  32'(stb),  32'd0);
         check_eq("term0_done", 32'(done), 32'(c == 3));
      end

      // Randomized messages with random backpressure and stray starts.
      for (int m = 0; m < 40; m++) begin
         rst = 1'b1;
         step();
         rst = 1'b0;
         exp_q.delete();
         for (int i = 0; i < int'(MSGLEN); i++)
            ram[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         for (int i = 0; i < int'(MSGLEN); i++) begin
            if (ram[i] == 8'h00) break;
            exp_q.push_back(ram[i]);
         end
         abort_at  = (m % 5 == 3) ? int'($urandom_range(2, 20)) : 0;
         start     = 1'b1;
         cyc       = 0;
         n_xfer    = 0;
         saw_done  = 1'b0;
         prev_hold = 1'b0;
         prev_data = '0;
         while (!saw_done && cyc < 400) begin
            step();
            cyc++;
            start = ($urandom_range(0, 7) == 0);
            if (prev_hold) begin
               check_eq("rnd_hold_stb",  32'(stb),  32'd1);
               check_eq("rnd_hold_data", 32'(data), 32'(prev_data));
            end
            if (cyc == abort_at) begin
               rst     = 1'b1;
               busy_in = 1'($urandom_range(0, 1));
               step();
               check_eq("rnd_rst_stb",  32'(stb),      32'd0);
               check_eq("rnd_rst_busy", 32'(busy_out), 32'd0);
               check_eq("rnd_rst_addr", 32'(mem_addr), 32'd0);
               rst = 1'b0;
               break;
            end
            if (done) begin
               saw_done = 1'b1;
               check_eq("rnd_left", 32'(exp_q.size() - n_xfer), 32'd0);
            end
            busy_in = 1'($urandom_range(0, 1));
            if (stb && !busy_in) begin
               n_xfer++;
               if (n_xfer <= exp_q.size())
                  check_eq("rnd_data", 32'(data), 32'(exp_q[n_xfer - 1]));
               else
                  check_eq("rnd_count", 32'(n_xfer), 32'(exp_q.size()));
            end
            prev_hold = stb && busy_in;
            prev_data = data;
         end
         busy_in = 1'b0;
         if (cyc == abort_at) begin
            start = 1'b0;
            continue;
         end
         check_eq("rnd_done_seen", 32'(saw_done), 32'd1);
         for (int k = 1; k <= int'(PAUSE_CYCLES); k++) begin
            step();
            start = (k < int'(PAUSE_CYCLES) - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            check_eq("rnd_pause_done", 32'(done), 32'd0);
            check_eq("rnd_pause_stb",  32'(stb),  32'd0);
`ifdef PSALM_LOOP_EN
            check_eq("rnd_pause_busy", 32'(busy_out), 32'd1);
`else
            check_eq("rnd_pause_busy", 32'(busy_out), 32'(k < int'(PAUSE_CYCLES)));
`endif
         end
         start = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hello_psalm_sequencer.md
Name: hello_psalm_sequencer

Overview:
Read-side controller for the psalm block RAM. Walks the RAM from address 0, absorbs the one-cycle registered read latency, and presents each byte to a downstream serial transmitter over a strobe/busy handshake. Stops at a terminator byte or at the last message address, pulses done, then holds for an inter-message pause. Sits between the psalm RAM and the UART transmitter in the hello-world top level.

Parameters:
AW, 11, RAM address width; must match the RAM's W.
DW, 8, data width; must match the RAM's DW.
MSGLEN, 1600, number of bytes in the message; last address is MSGLEN-1; must satisfy 1 <= MSGLEN <= 2**AW.
TERM_CHAR, 8'h00, terminator byte; ends the message early and is never transmitted.
PAUSE_CYCLES, 1000, inter-message gap in clocks; 32-bit counter; must be >= 1.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request; sampled only in IDLE
o_mem_addr  output  AW  RAM read address
i_mem_data  input  DW  RAM registered read data; valid one clock after o_mem_addr is presented
o_stb  output  1  byte valid to transmitter
o_data  output  DW  byte to transmit
i_busy  input  1  transmitter busy
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse at end of message

Behaviour:
- Reset (synchronous, priority over everything; effective mid-operation too): state=IDLE, o_mem_addr=0, o_stb=0, o_data=0, o_done=0, pause counter=0. Any strobe in progress is dropped on the reset edge with no completion.
- States are IDLE, FETCH, LOAD, SEND and PAUSE.
- IDLE: when i_start=1, set o_mem_addr to 0 and go to FETCH. Otherwise hold.
- FETCH: address is stable; the RAM samples it this cycle. Go to LOAD unconditionally.
- LOAD: i_mem_data is valid.
  - If i_mem_data==TERM_CHAR, finish.
  - Otherwise latch o_data<=i_mem_data, set o_stb<=1 and go to SEND.
- SEND: a transfer completes on any cycle with o_stb=1 and i_busy=0.
  - On transfer, clear o_stb.
  - If o_mem_addr==MSGLEN-1, finish.
  - Otherwise increment o_mem_addr and go to FETCH.
  - While i_busy=1, o_stb and o_data hold stable. o_data never changes while o_stb=1.
- finish: o_done=1 for exactly one cycle, the cycle after the finishing edge. Load the counter with PAUSE_CYCLES-1 and go to PAUSE.
- PAUSE: decrement the counter each clock. When the counter is 0, leave PAUSE; the destination depends on PSALM_LOOP_EN.
- Latency: i_start at cycle 0 gives FETCH at cycle 1, LOAD at cycle 2, and o_stb high at cycle 3. With i_busy tied low, each further byte costs 3 cycles (SEND, FETCH, LOAD).
- Address arithmetic:
  - o_mem_addr never exceeds MSGLEN-1.
  - With MSGLEN=2**AW, the last address is all-ones and no increment past it occurs; there is no wrap.
  - The pause counter never underflows.
- i_start is ignored outside IDLE, including when it coincides with o_done.
- o_mem_addr holds its value through PAUSE and IDLE until the next start.
- Terminator at address 0: no byte is sent. o_done is high 2 cycles after the FETCH cycle.

Optional Feature:
Macro PSALM_LOOP_EN.
- Defined: PAUSE exits directly to FETCH with o_mem_addr=0, so the message repeats forever after one i_start. i_start is still needed from IDLE after reset.
- Undefined: PAUSE exits to IDLE, and each message requires a new i_start.

Test Plan:
- MSGLEN=4, RAM={41,42,43,44}, i_busy=0, i_start pulsed at cycle 0 -> o_stb high in cycles 3, 6, 9 and 12 with o_data=41, 42, 43, 44; o_done high at cycle 13; o_busy high until PAUSE expires.
- RAM={48,00,49}, MSGLEN=3 -> only 48 is sent; o_done pulses; byte 49 is never strobed; o_mem_addr stays at 1.
- i_busy held high for 10 cycles after the first o_stb -> o_stb and o_data=41 held for all 10 cycles; exactly one transfer when i_busy drops; no duplicated or skipped bytes.
- i_reset asserted while in SEND with o_stb=1 -> next cycle o_stb=0, o_mem_addr=0, o_busy=0; a fresh i_start replays the message from byte 0.
- PAUSE_CYCLES=5, macro undefined -> o_busy falls exactly 5 cycles after o_done; an i_start during PAUSE is ignored. Macro defined -> FETCH re-entered at address 0 after 5 cycles without i_start, and o_data=41 is strobed again.
